// File: rtl/bsearch_pkg.sv
// Shared types for the parametrised binary search block: FSM state and search mode encodings.
package bsearch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROBE = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_LB    = 1'b1
  } mode_t;

endpackage

// File: rtl/bsearch_param_datapath.sv
// Datapath for the binary search: half-open [lo, hi) interval, probe point,
// latched key/mode, comparators, probe counter and registered results.
module bsearch_param_datapath
  import bsearch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int DESCEND = 0,
  parameter int PROBE_W = $clog2(ADDR_W + 2)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               probe_en,
  input  logic               cmp_en,
  input  logic               mode_in,
  input  logic [DATA_W-1:0]  target_in,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  mid_addr,
  output logic               range_empty,
  output logic               exact_hit,
  output logic               found,
  output logic [ADDR_W:0]    index,
  output logic [PROBE_W-1:0] probes
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(2 ** ADDR_W);

  logic [PTR_W-1:0]   lo;
  logic [PTR_W-1:0]   hi;
  logic [PTR_W-1:0]   span;
  logic [PTR_W-1:0]   mid;
  logic [DATA_W-1:0]  target_q;
  mode_t              mode_q;
  logic [PROBE_W-1:0] probe_cnt;
  logic               found_work;
  logic               less;
  logic               eq;

  // Overflow-free midpoint; "less" flips sense for a descending memory.
  assign span        = hi - lo;
  assign mid         = lo + (span >> 1);
  assign mid_addr    = mid[ADDR_W-1:0];
  assign range_empty = (lo == hi);
  assign eq          = (mem_rdata == target_q);
  assign less        = (DESCEND != 0) ? (mem_rdata > target_q) : (mem_rdata < target_q);
  assign exact_hit   = (mode_q == MODE_EXACT) && eq;

  // Narrow the search interval after each compare unless an exact hit ends the search.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo <= '0;
      hi <= DEPTH_P;
    end else if (load) begin
      lo <= '0;
      hi <= DEPTH_P;
    end else if (cmp_en && !exact_hit) begin
      if (less) lo <= mid + 1'b1;
      else      hi <= mid;
    end
  end

  // Latch key and mode at start; track probes used and whether any probe matched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q   <= '0;
      mode_q     <= MODE_EXACT;
      probe_cnt  <= '0;
      found_work <= 1'b0;
    end else if (load) begin
      target_q   <= target_in;
      mode_q     <= mode_t'(mode_in);
      probe_cnt  <= '0;
      found_work <= 1'b0;
    end else begin
      if (probe_en && !range_empty) probe_cnt <= probe_cnt + 1'b1;
      if (cmp_en && eq)             found_work <= 1'b1;
    end
  end

  // Results update only on the edge that enters DONE, so they stay stable while done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index  <= '0;
      found  <= 1'b0;
      probes <= '0;
    end else if (probe_en && range_empty) begin
      index  <= lo;
      found  <= found_work;
      probes <= probe_cnt;
    end else if (cmp_en && exact_hit) begin
      index  <= mid;
      found  <= 1'b1;
      probes <= probe_cnt;
    end
  end

endmodule

// File: rtl/binary_search_param.sv
// Binary search over an external sorted synchronous-read memory.
// Holds the control FSM and read-latency counter; the datapath does the arithmetic.
module binary_search_param
  import bsearch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int RD_LAT  = 1,
  parameter int DESCEND = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            mode,
  input  logic [DATA_W-1:0]               target,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic [ADDR_W:0]                 index,
  output logic [$clog2(ADDR_W + 2)-1:0]   probes,
  output logic [2:0]                      state
);

  localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         wait_cnt;
  logic               load;
  logic               probe_en;
  logic               cmp_en;
  logic               range_empty;
  logic               exact_hit;
  logic [ADDR_W-1:0]  mid_addr;

  bsearch_param_datapath #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DESCEND (DESCEND),
    .PROBE_W ($clog2(ADDR_W + 2))
  ) u_datapath (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .probe_en    (probe_en),
    .cmp_en      (cmp_en),
    .mode_in     (mode),
    .target_in   (target),
    .mem_rdata   (mem_rdata),
    .mid_addr    (mid_addr),
    .range_empty (range_empty),
    .exact_hit   (exact_hit),
    .found       (found),
    .index       (index),
    .probes      (probes)
  );

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Extra read-latency cycles: armed in PROBE, counted down through WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             wait_cnt <= '0;
    else if (state_q == PROBE)                wait_cnt <= WAIT_INIT;
    else if (state_q == WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 1'b1;
  end

  // Next-state logic; start is looked at only in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PROBE;
      PROBE:   begin
        if (range_empty)     state_d = DONE;
        else if (RD_LAT > 1) state_d = WAIT;
        else                 state_d = CMP;
      end
      WAIT:    if (wait_cnt == 0) state_d = CMP;
      CMP:     state_d = exact_hit ? DONE : PROBE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs, datapath strobes and the memory address (parked at 0 when not busy).
  always_comb begin
    busy     = (state_q == PROBE) || (state_q == WAIT) || (state_q == CMP);
    done     = (state_q == DONE);
    load     = (state_q == IDLE) && start;
    probe_en = (state_q == PROBE);
    cmp_en   = (state_q == CMP);
    mem_addr = busy ? mid_addr : '0;
  end

endmodule

// File: tb/tb_binary_search_param.sv
// Bench for binary_search_param: two instances (ascending RD_LAT=1, descending RD_LAT=3)
// against memory models, checked against a reference search model.
module tb_binary_search_param;
  import bsearch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       start_a, mode_a, busy_a, done_a, found_a;
  logic [7:0] target_a, rdata_a;
  logic [4:0] addr_a;
  logic [5:0] index_a;
  logic [2:0] probes_a, state_a;

  logic       start_b, mode_b, busy_b, done_b, found_b;
  logic [7:0] target_b, rdata_b;
  logic [4:0] addr_b;
  logic [5:0] index_b;
  logic [2:0] probes_b, state_b;

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] pipe_b [3];

  int checks = 0;
  int failures = 0;

  int exp_a_index, exp_a_probes, exp_b_index, exp_b_probes;
  bit exp_a_found, exp_b_found;
  bit check_a_en = 1'b0;
  bit check_b_en = 1'b0;
  logic [4:0] held_addr_b = '0;

  binary_search_param #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .DESCEND(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode_a), .target(target_a),
    .mem_addr(addr_a), .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
    .found(found_a), .index(index_a), .probes(probes_a), .state(state_a)
  );

  binary_search_param #(.DATA_W(8), .ADDR_W(5), .RD_LAT(3), .DESCEND(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b), .target(target_b),
    .mem_addr(addr_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
    .found(found_b), .index(index_b), .probes(probes_b), .state(state_b)
  );

  // Synchronous-read memories: one-cycle for dut_a, three-stage pipeline for dut_b.
  always @(posedge clk) rdata_a <= mem_a[addr_a];

  always @(posedge clk) begin
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: lower-bound answer from a linear scan; probe count and exact-hit
  // position from a plain iterative bisection of the index range.
  function automatic void bs_model(input logic [7:0] arr [32], input bit desc, input bit lb,
                                   input logic [7:0] key, input int lat,
                                   output int idx, output bit fnd, output int nprobe,
                                   output int cycles);
    int lo, hi, mid, first_ge;
    bit hit;
    first_ge = 32;
    for (int i = 31; i >= 0; i--)
      if (!(desc ? (arr[i] > key) : (arr[i] < key))) first_ge = i;
    lo = 0; hi = 32; hit = 1'b0; nprobe = 0; idx = first_ge;
    while (lo < hi && !hit) begin
      mid = (lo + hi) / 2;
      nprobe++;
      if (!lb && arr[mid] == key) begin
        hit = 1'b1;
        idx = mid;
      end else if (desc ? (arr[mid] > key) : (arr[mid] < key)) lo = mid + 1;
      else hi = mid;
    end
    fnd = hit;
    if (lb && first_ge < 32) fnd = (arr[first_ge] == key);
    cycles = (lat + 1) * nprobe + (hit ? 0 : 1);
  endfunction

  // Compare process: results against the model whenever done is up, and
  // dut_b's address stability from PROBE through CMP.
  always @(negedge clk) begin
    if (check_a_en && done_a) begin
      check_output("a_index",  int'(index_a),  exp_a_index);
      check_output("a_found",  int'(found_a),  int'(exp_a_found));
      check_output("a_probes", int'(probes_a), exp_a_probes);
    end
    if (check_b_en && done_b) begin
      check_output("b_index",  int'(index_b),  exp_b_index);
      check_output("b_found",  int'(found_b),  int'(exp_b_found));
      check_output("b_probes", int'(probes_b), exp_b_probes);
    end
    if (state_b == 3'd1) held_addr_b = addr_b;
    else if (state_b == 3'd2 || state_b == 3'd3)
      check_output("b_addr_stable", int'(addr_b), int'(held_addr_b));
  end

  task automatic wait_done(input bit use_b, input int exp_cycles, input string name);
    int edges = 0;
    while (!(use_b ? done_b : done_a) && edges < 500) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!(use_b ? done_b : done_a)) check_output({name, "_timeout"}, 0, 1);
    check_output({name, "_latency"}, edges, exp_cycles);
  endtask

  // Run one search; key/mode are scrambled after sampling to show they are ignored.
  task automatic apply_stimulus(input bit use_b, input bit m, input logic [7:0] t,
                                input int hold_cycles, input string name,
                                output int idx, output bit fnd, output int nprobe,
                                output int cycles);
    if (use_b) bs_model(mem_b, 1'b1, m, t, 3, idx, fnd, nprobe, cycles);
    else       bs_model(mem_a, 1'b0, m, t, 1, idx, fnd, nprobe, cycles);
    if (use_b) begin
      exp_b_index = idx; exp_b_found = fnd; exp_b_probes = nprobe; check_b_en = 1'b1;
    end else begin
      exp_a_index = idx; exp_a_found = fnd; exp_a_probes = nprobe; check_a_en = 1'b1;
    end
    @(negedge clk);
    if (use_b) begin start_b = 1'b1; mode_b = m; target_b = t; end
    else       begin start_a = 1'b1; mode_a = m; target_a = t; end
    @(posedge clk); #1;
    if (use_b) begin start_b = (hold_cycles > 0); mode_b = ~m; target_b = ~t; end
    else       begin start_a = (hold_cycles > 0); mode_a = ~m; target_a = ~t; end
    wait_done(use_b, cycles, name);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check_output({name, "_done_held"}, int'(use_b ? done_b : done_a), 1);
    end
    @(negedge clk);
    if (use_b) start_b = 1'b0; else start_a = 1'b0;
    @(posedge clk); #1;
    check_output({name, "_back_idle"}, int'(use_b ? state_b : state_a), 0);
    check_output({name, "_done_low"},  int'(use_b ? done_b : done_a), 0);
    check_a_en = 1'b0;
    check_b_en = 1'b0;
  endtask

  task automatic pin_model(input string name, input int idx, input bit fnd, input int nprobe,
                           input int cycles, input int l_idx, input int l_fnd,
                           input int l_probes, input int l_cycles);
    check_output({name, "_model_index"}, idx, l_idx);
    check_output({name, "_model_found"}, int'(fnd), l_fnd);
    if (l_probes >= 0) check_output({name, "_model_probes"}, nprobe, l_probes);
    if (l_cycles >= 0) check_output({name, "_model_cycles"}, cycles, l_cycles);
  endtask

  initial begin
    int idx, nprobe, cycles;
    bit fnd;

    reset_n = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; target_a = '0;
    start_b = 1'b0; mode_b = 1'b0; target_b = '0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'(2 * i);
      mem_b[i] = 8'(62 - 2 * i);
    end
    repeat (3) @(negedge clk);
    check_output("rst_state",    int'(state_a),  0);
    check_output("rst_busy",     int'(busy_a),   0);
    check_output("rst_done",     int'(done_a),   0);
    check_output("rst_found",    int'(found_a),  0);
    check_output("rst_index",    int'(index_a),  0);
    check_output("rst_probes",   int'(probes_a), 0);
    check_output("rst_mem_addr", int'(addr_a),   0);
    reset_n = 1'b1;

    $display("[TB] ascending, RD_LAT=1, mem[i]=2*i");
    apply_stimulus(1'b0, 1'b0, 8'd8, 0, "ex8", idx, fnd, nprobe, cycles);
    pin_model("ex8", idx, fnd, nprobe, cycles, 4, 1, 3, 6);
    apply_stimulus(1'b0, 1'b0, 8'd9, 0, "ex9", idx, fnd, nprobe, cycles);
    pin_model("ex9", idx, fnd, nprobe, cycles, 5, 0, 5, 11);
    apply_stimulus(1'b0, 1'b1, 8'd9, 0, "lb9", idx, fnd, nprobe, cycles);
    pin_model("lb9", idx, fnd, nprobe, cycles, 5, 0, -1, -1);
    apply_stimulus(1'b0, 1'b1, 8'd200, 0, "lb200", idx, fnd, nprobe, cycles);
    pin_model("lb200", idx, fnd, nprobe, cycles, 32, 0, 5, 11);
    apply_stimulus(1'b0, 1'b1, 8'd0, 0, "lb0", idx, fnd, nprobe, cycles);
    pin_model("lb0", idx, fnd, nprobe, cycles, 0, 1, -1, -1);
    apply_stimulus(1'b0, 1'b0, 8'd8, 3, "hold", idx, fnd, nprobe, cycles);

    $display("[TB] duplicates, mem[i]=min(i,10)");
    for (int i = 0; i < 32; i++) mem_a[i] = (i < 10) ? 8'(i) : 8'd10;
    apply_stimulus(1'b0, 1'b1, 8'd10, 0, "duplb", idx, fnd, nprobe, cycles);
    pin_model("duplb", idx, fnd, nprobe, cycles, 10, 1, -1, -1);
    apply_stimulus(1'b0, 1'b0, 8'd10, 0, "dupex", idx, fnd, nprobe, cycles);
    pin_model("dupex", idx, fnd, nprobe, cycles, 16, 1, 1, 2);

    $display("[TB] descending, RD_LAT=3, mem[i]=62-2*i");
    apply_stimulus(1'b1, 1'b0, 8'd54, 0, "desc54", idx, fnd, nprobe, cycles);
    pin_model("desc54", idx, fnd, nprobe, cycles, 4, 1, 3, 12);

    $display("[TB] asynchronous reset during third probe");
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(2 * i);
    @(negedge clk);
    start_a = 1'b1; mode_a = 1'b0; target_a = 8'd9;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_output("pre_reset_cmp", int'(state_a), 3);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_state",    int'(state_a),  0);
    check_output("mid_rst_busy",     int'(busy_a),   0);
    check_output("mid_rst_done",     int'(done_a),   0);
    check_output("mid_rst_found",    int'(found_a),  0);
    check_output("mid_rst_index",    int'(index_a),  0);
    check_output("mid_rst_probes",   int'(probes_a), 0);
    check_output("mid_rst_mem_addr", int'(addr_a),   0);

    start_a = 1'b1; mode_a = 1'b0; target_a = 8'd8;
    exp_a_index = 4; exp_a_found = 1'b1; exp_a_probes = 3; check_a_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; target_a = 8'd99;
    wait_done(1'b0, 6, "post_rst");
    @(negedge clk);
    @(posedge clk); #1;
    check_output("post_rst_idle", int'(state_a), 0);
    check_a_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_search_param.md
# binary_search_param

- Parametrised successor to the fixed 32x8 binary search block.
- Performs a binary search over an externally owned, sorted, synchronous-read memory.
- Width, depth, read latency and sort direction are set by parameters. Two modes are selected per search: exact match, or lower-bound (first index whose value is >= target, or <= target when descending).
- Sits between a control FSM or CPU-side start/target source and a single-port ROM/RAM; it owns the read port while busy.

## Interface
Parameters:
- DATA_W, 8, element width
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W
- RD_LAT, 1, memory read latency in cycles (1..4); address to valid mem_rdata
- DESCEND, 0, 1 = memory sorted descending

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled only in IDLE
- mode  in  1  0 = exact, 1 = lower-bound; latched with start
- target  in  DATA_W  search key; latched with start
- mem_addr  out  ADDR_W  read address to memory
- mem_rdata  in  DATA_W  read data from memory
- busy  out  1  high in PROBE/WAIT/CMP
- done  out  1  high in DONE
- found  out  1  result flag, valid while done
- index  out  ADDR_W+1  result index (0..DEPTH), valid while done
- probes  out  $clog2(ADDR_W+2)  memory probes used by the last search
- state  out  3  current FSM state, for debug

## Operation
- Search interval is half-open [lo, hi), with lo and hi each ADDR_W+1 bits.
- Probe point: mid = lo + ((hi - lo) >> 1). This form is overflow-free; mem_addr = mid[ADDR_W-1:0].
- "less" means mem_rdata < target_q when DESCEND=0, and mem_rdata > target_q when DESCEND=1. eq is exact equality.
- FSM states: IDLE, PROBE, WAIT, CMP, DONE.
- IDLE → PROBE when start=1. On that edge: lo=0, hi=DEPTH, probes=0, found=0; target and mode are latched.
- PROBE, lo==hi → DONE, with index=lo.
- PROBE, lo!=hi → WAIT if RD_LAT>1, else → CMP. probes increments.
- WAIT: stays RD_LAT-1 cycles, then → CMP. mem_addr is held stable from PROBE through CMP.
- CMP, exact mode:
  - eq → DONE, index=mid, found=1.
  - less → lo=mid+1, else hi=mid; then → PROBE.
- CMP, lower-bound mode:
  - less → lo=mid+1, else hi=mid.
  - eq additionally sets found=1.
  - → PROBE. The result on termination is the first occurrence among duplicates.
- Exact mode with no hit: index = insertion point (lo), found=0.
- DONE: holds results. → IDLE when start=0. start held high does not retrigger.
- Inputs target and mode are ignored while not in IDLE.

## Timing
- Reset (any state, asynchronous):
  - state=IDLE, done=0, busy=0, found=0.
  - index=0, probes=0, mem_addr=0, lo=0, hi=DEPTH.
- Each probe costs RD_LAT+1 cycles. Terminating on lo==hi costs one extra PROBE cycle.
- With P probes, done rises:
  - exact hit: (RD_LAT+1)*P edges after the start-sampling edge;
  - otherwise: (RD_LAT+1)*P + 1 edges after it.
- Maximum probe count is ADDR_W+1.
- Results are registered and change only on entering DONE or on reset.
- Reset released with start already high: search begins on the first edge after release.

## Structure
- Package bsearch_pkg holds:
  - state enum typedef (3-bit, IDLE=0, PROBE=1, WAIT=2, CMP=3, DONE=4);
  - mode enum (MODE_EXACT=0, MODE_LB=1).
- One sub-module, bsearch_param_datapath: lo/hi/mid registers, target/mode latches, comparators, probe counter and result registers.
- The top level holds the FSM and the WAIT latency counter, and drives datapath load/update strobes.

## Test plan
Unless noted: DEPTH=32, RD_LAT=1, mem[i]=2*i.
- Exact, target 8 → after 3 probes: found=1, index=4, probes=3; done 6 edges after start sampled.
- Exact, target 9 → found=0, index=5, probes=5. Lower-bound, target 9 → index=5, found=0.
- Lower-bound, target 200 → index=32, found=0, probes=5. Target 0 → index=0, found=1.
- Duplicates, mem[i]=min(i,10):
  - lower-bound, target 10 → index=10, found=1;
  - exact, target 10 → index=16, found=1, probes=1.
- RD_LAT=3, DESCEND=1, mem[i]=62-2*i, exact, target 54 → found=1, index=4. Every probe spans 4 cycles; mem_addr is stable across WAIT.
- Control and reset:
  - reset_n low during the third probe's CMP → all outputs at reset values immediately.
  - Release with start=1 → fresh search.
  - Holding start=1 in DONE keeps done=1; start=0 → IDLE next edge.
  - Changing target while busy has no effect.
